// File: rtl/fifo_rptr_empty_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rptr_empty_gen_if
// Description : Read-side port bundle of the asynchronous FIFO: consumer
//               requests, synchronised write pointer input and read status.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rptr_empty_gen_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 r_en;
    logic [ADDR_SIZE:0]   w_ptr;
    logic                 underflow_clr;
    logic [ADDR_SIZE:0]   r_ptr;
    logic [ADDR_SIZE-1:0] r_addr;
    logic                 r_empty;
    logic                 r_almost_empty;
    logic [ADDR_SIZE:0]   r_level;
    logic                 r_valid;
    logic                 r_underflow;

    // Consumer / environment side
    modport master (
        output r_en, w_ptr, underflow_clr,
        input  r_ptr, r_addr, r_empty, r_almost_empty, r_level, r_valid, r_underflow
    );

    // Read-pointer controller side
    modport slave (
        input  r_en, w_ptr, underflow_clr,
        output r_ptr, r_addr, r_empty, r_almost_empty, r_level, r_valid, r_underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rptr_empty_gen.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rptr_empty_gen
// Description : Async FIFO read-side controller. Synchronises the Gray write
//               pointer, keeps binary/Gray read pointers and produces
//               registered empty, almost-empty, level, valid and underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rptr_empty_gen #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fifo_rptr_empty_gen_if.slave    bus
);
    localparam int            c_PW        = ADDR_SIZE + 1;
    localparam logic [c_PW-1:0] c_AE_THRESH = c_PW'(AE_THRESH);
    localparam logic [c_PW-1:0] c_ONE       = c_PW'(1);

    logic [c_PW-1:0] r_rbin;
    logic [c_PW-1:0] r_rgray;
    logic [c_PW-1:0] r_sync [SYNC_STAGES];
    logic            r_empty;
    logic            r_almost_empty;
    logic [c_PW-1:0] r_level;
    logic            r_valid;
    logic            r_underflow;

    logic            w_rd_ok;
    logic [c_PW-1:0] w_rbin_next;
    logic [c_PW-1:0] w_rgray_next;
    logic [c_PW-1:0] w_wq_gray;
    logic [c_PW-1:0] w_wq_bin;
    logic [c_PW-1:0] w_level_next;

    // Next-pointer arithmetic; a read while empty leaves the pointer unchanged
    assign w_rd_ok      = bus.r_en & ~r_empty;
    assign w_rbin_next  = w_rd_ok ? (r_rbin + c_ONE) : r_rbin;
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
    assign w_wq_gray    = r_sync[SYNC_STAGES-1];
    assign w_level_next = w_wq_bin - w_rbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    generate
        for (genvar gi = 0; gi < c_PW; gi++) begin : g_g2b
            assign w_wq_bin[gi] = ^w_wq_gray[c_PW-1:gi];
        end
    endgenerate

    // Write-pointer synchroniser chain into the read clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.w_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Read pointers and status flags, all reflecting the post-read state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbin         <= '0;
            r_rgray        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
            r_valid        <= 1'b0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rgray        <= w_rgray_next;
            r_empty        <= (w_rgray_next == w_wq_gray);
            r_almost_empty <= (w_level_next <= c_AE_THRESH);
            r_level        <= w_level_next;
            r_valid        <= w_rd_ok;
        end
    end

    // Sticky underflow; a new underflow takes priority over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (bus.r_en & r_empty) begin
            r_underflow <= 1'b1;
        end else if (bus.underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign bus.r_ptr          = r_rgray;
    assign bus.r_addr         = r_rbin[ADDR_SIZE-1:0];
    assign bus.r_empty        = r_empty;
    assign bus.r_almost_empty = r_almost_empty;
    assign bus.r_level        = r_level;
    assign bus.r_valid        = r_valid;
    assign bus.r_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rptr_empty_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rptr_empty_gen
// Description : Self-checking bench for fifo_rptr_empty_gen using a word-count
//               reference model (writes issued vs. reads accepted).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rptr_empty_gen;
    localparam int AS   = 4;
    localparam int SYNC = 2;
    localparam int DEP  = 1 << AS;
    localparam int MOD  = 2 * DEP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fifo_rptr_empty_gen_if #(.ADDR_SIZE(AS)) bus ();

    fifo_rptr_empty_gen #(.ADDR_SIZE(AS), .SYNC_STAGES(SYNC), .AE_THRESH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: counts of words written and read, plus the write count
    // as seen by the read side SYNC edges ago.
    int wcnt;
    int m_rd;
    int wh [SYNC];
    bit m_empty, m_ae, m_valid, m_uf;
    int m_level;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wcnt = 0; m_rd = 0;
        for (int i = 0; i < SYNC; i++) wh[i] = 0;
        m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0; m_level = 0;
    endtask

    task automatic check_all(input string tag);
        int rb;
        rb = m_rd % MOD;
        chk({tag, ":r_ptr"},   32'(bus.r_ptr),   32'(rb ^ (rb >> 1)));
        chk({tag, ":r_addr"},  32'(bus.r_addr),  32'(m_rd % DEP));
        chk({tag, ":empty"},   32'(bus.r_empty), 32'(m_empty));
        chk({tag, ":ae"},      32'(bus.r_almost_empty), 32'(m_ae));
        chk({tag, ":level"},   32'(bus.r_level), 32'(m_level));
        chk({tag, ":valid"},   32'(bus.r_valid), 32'(m_valid));
        chk({tag, ":uf"},      32'(bus.r_underflow), 32'(m_uf));
    endtask

    // One clock: apply inputs, advance the model at the edge, check after it
    task automatic step(input bit ren, input bit wr, input bit clr, input string tag);
        int wb, wq, rd_ok;
        if (wr) wcnt++;
        wb = wcnt % MOD;
        bus.w_ptr = (AS+1)'(wb ^ (wb >> 1));
        bus.r_en = ren;
        bus.underflow_clr = clr;
        @(posedge clk);
        wq = wh[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) wh[i] = wh[i-1];
        wh[0] = wcnt;
        rd_ok = (ren && !m_empty) ? 1 : 0;
        if (ren && m_empty) m_uf = 1;
        else if (clr) m_uf = 0;
        m_rd += rd_ok;
        m_level = (wq - m_rd) % MOD;
        m_empty = (m_level == 0);
        m_ae = (m_level <= 1);
        m_valid = (rd_ok != 0);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ":async_empty"}, 32'(bus.r_empty), 32'd1);
        chk({tag, ":async_level"}, 32'(bus.r_level), 32'd0);
        chk({tag, ":async_ptr"},   32'(bus.r_ptr),   32'd0);
        check_all({tag, ":async"});
        bus.w_ptr = '0; bus.r_en = 1'b0; bus.underflow_clr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.r_en = 1'b0; bus.w_ptr = '0; bus.underflow_clr = 1'b0;
        model_reset();
        #23;

        // Reset asserted between edges takes effect immediately
        do_reset("rst");
        for (int i = 0; i < 10; i++) step(0, 0, 0, "idle");

        // Single write: empty falls on the third edge, then one read drains it
        step(0, 1, 0, "w1_e1");
        step(0, 0, 0, "w1_e2");
        step(0, 0, 0, "w1_e3");
        chk("single:empty_fell", 32'(bus.r_empty), 32'd0);
        chk("single:level1",     32'(bus.r_level), 32'd1);
        step(1, 0, 0, "single_rd");
        chk("single:addr1",  32'(bus.r_addr),  32'd1);
        chk("single:empty1", 32'(bus.r_empty), 32'd1);
        chk("single:valid",  32'(bus.r_valid), 32'd1);
        step(0, 0, 0, "single_post");

        // Fill and drain three laps to exercise pointer wrap
        for (int lap = 0; lap < 3; lap++) begin
            while (wcnt - m_rd < DEP) step(0, 1, 0, "fill");
            for (int i = 0; i <= SYNC; i++) step(0, 0, 0, "settle");
            chk("full:level", 32'(bus.r_level), 32'(DEP));
            for (int i = 0; i < DEP; i++) step(1, 0, 0, "drain");
            chk("drain:empty", 32'(bus.r_empty), 32'd1);
        end

        // Underflow: set, set-wins-over-clear, then clear alone
        step(1, 0, 0, "uf_set");
        chk("uf:set", 32'(bus.r_underflow), 32'd1);
        step(1, 0, 1, "uf_setclr");
        chk("uf:setwins", 32'(bus.r_underflow), 32'd1);
        step(0, 0, 1, "uf_clr");
        chk("uf:clr", 32'(bus.r_underflow), 32'd0);

        // Randomised traffic never exceeding DEPTH words outstanding
        for (int i = 0; i < 400; i++) begin
            bit wr, rd, cl;
            wr = ($urandom_range(0, 99) < 55) && (wcnt - m_rd < DEP);
            rd = ($urandom_range(0, 99) < 50);
            cl = ($urandom_range(0, 99) < 10);
            step(rd, wr, cl, "rand");
        end

        // Reset in the middle of a drain, then recover from a cold start
        while (wcnt - m_rd < DEP) step(0, 1, 0, "refill");
        for (int i = 0; i <= SYNC; i++) step(0, 0, 0, "settle2");
        while (m_level > 8) step(1, 0, 0, "part_drain");
        chk("mid:level8", 32'(bus.r_level), 32'd8);
        do_reset("mid_rst");
        for (int i = 0; i < 5; i++) step(0, 1, 0, "recover_w");
        for (int i = 0; i < 12; i++) step(1, 0, 0, "recover_r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fifo_rptr_empty_gen.md
# fifo_rptr_empty_gen

Parametrised read-side controller for the asynchronous FIFO. It synchronises the Gray-coded write pointer into the read clock domain and maintains the read pointer in binary and Gray form. It generates registered empty, almost-empty, fill-level, read-valid and sticky-underflow status. It replaces the fixed two-flop read-pointer logic and drives the read port of the dual-port FIFO memory.

## Interface

- ADDR_SIZE, 4, memory address width; DEPTH = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits wide.
- SYNC_STAGES, 2, number of write-pointer synchroniser flops; legal range is 2 or more.
- AE_THRESH, 1, almost-empty threshold in words; legal range is 0..DEPTH.

Ports:

- clk  in  1  read-domain clock; all flops are clocked on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- r_en  in  1  read request from the consumer.
- w_ptr  in  ADDR_SIZE+1  Gray-coded write pointer from the write domain (asynchronous to clk).
- underflow_clr  in  1  clears r_underflow.
- r_ptr  out  ADDR_SIZE+1  registered Gray read pointer, sent to the write domain.
- r_addr  out  ADDR_SIZE  registered binary read address, equal to rbin[ADDR_SIZE-1:0].
- r_empty  out  1  registered empty flag.
- r_almost_empty  out  1  registered flag, high when the level is at or below AE_THRESH.
- r_level  out  ADDR_SIZE+1  registered fill level in words, range 0..DEPTH.
- r_valid  out  1  pulses high for one cycle after each accepted read; aligns with the synchronous RAM read data.
- r_underflow  out  1  sticky flag: a read was attempted while empty.

## Operation

**Accepted read**
- rd_ok = r_en & ~r_empty.
- rbin_next = rbin + rd_ok, computed modulo 2^(ADDR_SIZE+1).
- rgray_next = rbin_next ^ (rbin_next >> 1).
- Registers update every cycle: rbin <= rbin_next; r_ptr <= rgray_next.

**Synchroniser**
- A chain of SYNC_STAGES registers, each ADDR_SIZE+1 bits, carries w_ptr.
- The output of the last stage is wq_gray.
- wq_bin is the combinational Gray-to-binary conversion of wq_gray (prefix XOR from the MSB).

**Status flags and level**
- r_empty <= (rgray_next == wq_gray).
- level_next = (wq_bin - rbin_next), computed modulo 2^(ADDR_SIZE+1).
- r_level <= level_next.
- r_almost_empty <= (level_next <= AE_THRESH).
- r_valid <= rd_ok.

**Underflow**
- r_underflow is set when r_en & r_empty.
- Otherwise it is cleared when underflow_clr is high.
- Set wins when set and clear occur in the same cycle.

**Ordering and wrap-around**
- A read while empty is ignored: pointers hold and r_valid stays 0.
- Pointers wrap naturally at 2^(ADDR_SIZE+1).
- The pointer MSB distinguishes laps; r_addr wraps at DEPTH.

**Pessimism**
- r_level and r_empty lag real writes by the synchroniser latency, so they never over-report available data.
- A r_level of DEPTH is legal and corresponds to a full FIFO.

**Reset state**
- Asserting rst forces immediately, regardless of clk: rbin=0, r_ptr=0, r_addr=0, all synchroniser stages=0, r_empty=1, r_almost_empty=1, r_level=0, r_valid=0, r_underflow=0.
- Reset mid-operation discards any in-flight read; the first edge after deassertion behaves as from a cold start.

## Timing

**Read path**
- An accepted read on edge k updates r_ptr, r_addr, r_level and r_empty on edge k.
- The updated values reflect the post-read state; there is no extra cycle of latency.
- r_valid is high during the cycle following edge k.

**Write-to-empty path**
- Once w_ptr changes and is stable, wq_gray takes the new value after SYNC_STAGES rising edges.
- r_empty, r_level and r_almost_empty follow one edge later, for a total of SYNC_STAGES+1 edges.

**Back-to-back reads**
- Back-to-back reads are sustained at one per cycle while data is available.
- When the last word is read, r_empty rises on that same edge.
- r_en held high after that point produces r_underflow=1 on the next edge.

**Input requirement**
- w_ptr must change by at most one Gray step per write-clock edge.

## Test plan

1. **Reset:** assert rst mid-cycle with clk stopped -> all outputs take their reset values immediately (r_empty=1, r_level=0); release rst, hold w_ptr=0 for 10 cycles -> no change.
2. **Single write:** ADDR_SIZE=4, SYNC_STAGES=2; w_ptr 0->1 (Gray) -> r_empty falls and r_level=1 on the 3rd edge; r_en for one cycle -> r_addr=1, r_ptr=1, r_empty=1, r_level=0 on that edge; r_valid=1 in the next cycle.
3. **Full then drain:** step w_ptr through 16 Gray values to 5'b11000 (bin 16) -> r_level=16; 16 consecutive reads -> r_addr 0..15 then 0, r_level counts down to 0, r_almost_empty rises when r_level reaches 1.
4. **Wrap-around:** repeat scenario 3 for three laps -> r_ptr MSB toggles each lap; no spurious r_empty deassertion with wq_gray==r_ptr on a different lap.
5. **Underflow:** r_en=1 while empty -> r_underflow=1 with pointers unchanged; assert underflow_clr together with a new empty read -> flag stays 1; underflow_clr alone -> flag 0 next edge.
6. **Reset mid-drain:** with r_level=8, pulse rst -> pointers return to 0, r_empty=1; the bench restarts w_ptr at 0 and the read side recovers correctly.
